multi_box_drawer: RTL

MULTI_BOX_DRAWER -- requirements
Module: multi_box_drawer

---
 rtl/pong_pkg.sv | 21 ++
 rtl/box_fifo.sv | 62 ++++++
 rtl/multi_box_drawer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared widths, screen geometry, draw-mode encoding and drawer FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

  localparam int DEF_X_W           = 9;
  localparam int DEF_Y_W           = 8;
  localparam int DEF_COLOUR_W      = 3;
  localparam int DEF_SCREEN_WIDTH  = 320;
  localparam int DEF_SCREEN_HEIGHT = 240;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2
  } state_t;

endpackage

// File: rtl/box_fifo.sv
// Descriptor queue: power-of-two circular buffer with show-ahead head and occupancy count.
// Latency: a push is visible at the head one cycle after the accepting edge.
// Backpressure: full is raised at DEPTH entries; push while full and pop while empty are ignored.
module box_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/multi_box_drawer.sv
// Queued box rasteriser: draws filled or outlined rectangles one pixel per cycle, clipped to the screen.
// Latency: first pixel strobe 3 cycles after a descriptor is accepted into an idle, empty block.
// Backpressure: s_ready drops while the descriptor queue is full; back-to-back boxes chain with no idle cycle.
module multi_box_drawer
  import pong_pkg::*;
#(
  parameter int X_W           = DEF_X_W,
  parameter int Y_W           = DEF_Y_W,
  parameter int COLOUR_W      = DEF_COLOUR_W,
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [X_W-1:0]      in_box_x,
  input  logic [Y_W-1:0]      in_box_y,
  input  logic [X_W-1:0]      in_box_w,
  input  logic [Y_W-1:0]      in_box_h,
  input  logic [COLOUR_W-1:0] in_box_color,
  input  logic                in_mode,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic                plot,
  output logic [COLOUR_W-1:0] colour,
  output logic                busy
);

  localparam int DESC_W = 2*X_W + 2*Y_W + COLOUR_W + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [X_W:0]   SCR_W = (X_W+1)'(SCREEN_WIDTH);
  localparam logic [Y_W:0]   SCR_H = (Y_W+1)'(SCREEN_HEIGHT);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  // Descriptor queue
  logic [DESC_W-1:0] push_desc;
  logic [DESC_W-1:0] head_desc;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_push;
  logic              fifo_pop;

  // Head-of-queue fields
  logic [X_W-1:0]      hd_x, hd_w;
  logic [Y_W-1:0]      hd_y, hd_h;
  logic [COLOUR_W-1:0] hd_col;
  logic                hd_mode;

  // Working descriptor and raster position
  state_t              state_q;
  logic [X_W-1:0]      x_q, w_q, dx_q;
  logic [Y_W-1:0]      y_q, h_q, dy_q;
  logic [COLOUR_W-1:0] col_q;
  logic                mode_q;

  // Registered pixel outputs; pix_vld_q marks that a pixel is being presented this cycle
  logic [X_W-1:0]      vga_x_q;
  logic [Y_W-1:0]      vga_y_q;
  logic                plot_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                pix_vld_q;

  // Current pixel, computed one bit wider so an off-screen sum never wraps back on-screen
  logic [X_W:0] px_d;
  logic [Y_W:0] py_d;
  logic         last_col_d;
  logic         last_row_d;
  logic         plot_d;

  assign push_desc = {in_mode, in_box_color, in_box_h, in_box_w, in_box_y, in_box_x};
  assign {hd_mode, hd_col, hd_h, hd_w, hd_y, hd_x} = head_desc;

  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && s_ready;
  assign fifo_pop  = (state_q == LOAD);

  box_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_box_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_desc),
    .pop       (fifo_pop),
    .pop_data  (head_desc),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Pixel address, clip test and outline edge test for the raster position being visited
  always_comb begin
    px_d       = {1'b0, x_q} + {1'b0, dx_q};
    py_d       = {1'b0, y_q} + {1'b0, dy_q};
    last_col_d = (dx_q == w_q - X_ONE);
    last_row_d = (dy_q == h_q - Y_ONE);
    plot_d     = (px_d < SCR_W) && (py_d < SCR_H) &&
                 ((mode_q == MODE_FILL) ||
                  (dx_q == '0) || last_col_d || (dy_q == '0) || last_row_d);
  end

  // Drawer FSM: load a descriptor, then walk it row-major, registering one pixel per cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      mode_q    <= MODE_FILL;
      dx_q      <= '0;
      dy_q      <= '0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      plot_q    <= 1'b0;
      colour_q  <= '0;
      pix_vld_q <= 1'b0;
    end else begin
      plot_q    <= 1'b0;
      pix_vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) state_q <= LOAD;
        end
        LOAD: begin
          x_q    <= hd_x;
          y_q    <= hd_y;
          w_q    <= hd_w;
          h_q    <= hd_h;
          col_q  <= hd_col;
          mode_q <= hd_mode;
          dx_q   <= '0;
          dy_q   <= '0;
          // A zero-area box is consumed here without ever entering DRAW
          state_q <= ((hd_w != '0) && (hd_h != '0)) ? DRAW : IDLE;
        end
        DRAW: begin
          vga_x_q   <= px_d[X_W-1:0];
          vga_y_q   <= py_d[Y_W-1:0];
          plot_q    <= plot_d;
          colour_q  <= col_q;
          pix_vld_q <= 1'b1;
          if (last_col_d) begin
            dx_q <= '0;
            if (last_row_d) begin
              dy_q    <= '0;
              state_q <= fifo_empty ? IDLE : LOAD;
            end else begin
              dy_q <= dy_q + Y_ONE;
            end
          end else begin
            dx_q <= dx_q + X_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vga_x  = vga_x_q;
  assign vga_y  = vga_y_q;
  assign plot   = plot_q;
  assign colour = colour_q;
  // Busy also covers the cycle in which the final pixel is still on the outputs
  assign busy   = (|fifo_count) || (state_q != IDLE) || pix_vld_q;

endmodule
